// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the instruction-cache port, the hazard/redirect controls and the
// IF/ID latch feed of the fetch stage.
//   master : the fetch stage (drives iREN/iaddr, ifid_*, halted, fetch_count)
//   slave  : the surroundings (icache, hazard unit, later stages, IF/ID)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_next_pc;
    logic        ifid_en;
    logic        ifid_flush;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  ihit, iload, stall, redirect, redirect_pc,
        output iREN, iaddr, ifid_instr, ifid_pc, ifid_pc4, ifid_next_pc,
               ifid_en, ifid_flush, halted, fetch_count
    );

    modport slave (
        output ihit, iload, stall, redirect, redirect_pc,
        input  iREN, iaddr, ifid_instr, ifid_pc, ifid_pc4, ifid_next_pc,
               ifid_en, ifid_flush, halted, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, reads
// the icache, parks a returned instruction in a one-entry skid buffer while
// IF/ID is stalled, applies redirects, and stops fetching on HALT.
// Ports:
//   CLK  - clock
//   RST  - synchronous active-high reset
//   bus  - fetch_stage_if.master: icache port (ihit/iload/iREN/iaddr),
//          stall/redirect inputs, IF/ID data/en/flush, halted, fetch_count
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic        accept;

    // Fall-through prediction; wraps naturally at 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state logic. "accept" marks a cycle where IF/ID takes an
    // instruction; redirect always wins and discards any hit or buffer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ibuf_d  = ibuf_q;
        count_d = count_q;
        accept  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                end else if (bus.ihit && !bus.stall) begin
                    accept = 1'b1;
                    if (bus.iload == HALT_WORD) state_d = S_HALT;
                end else if (bus.ihit) begin
                    // Capture the word so the cache is not read again.
                    ibuf_d  = bus.iload;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = S_FETCH;
                end else if (!bus.stall) begin
                    accept  = 1'b1;
                    state_d = (ibuf_q == HALT_WORD) ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (accept) begin
            pc_d    = pc_plus4;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
            pc_q    <= PC_INIT;
            ibuf_q  <= 32'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
            count_q <= count_d;
        end
    end

    // Combinational outputs; everything towards IF/ID and the icache is
    // quiet while reset is asserted.
    always_comb begin
        bus.iaddr        = pc_q;
        bus.fetch_count  = count_q;
        bus.iREN         = 1'b0;
        bus.ifid_en      = 1'b0;
        bus.ifid_flush   = 1'b0;
        bus.halted       = 1'b0;
        bus.ifid_instr   = 32'd0;
        bus.ifid_pc      = 32'd0;
        bus.ifid_pc4     = 32'd0;
        bus.ifid_next_pc = 32'd0;
        if (!RST) begin
            bus.iREN         = (state_q == S_FETCH);
            bus.ifid_en      = accept;
            bus.ifid_flush   = bus.redirect;
            bus.halted       = (state_q == S_HALT);
            bus.ifid_pc      = pc_q;
            bus.ifid_pc4     = pc_plus4;
            bus.ifid_next_pc = pc_plus4;
            case (state_q)
                S_FETCH: bus.ifid_instr = bus.iload;
                S_HOLD:  bus.ifid_instr = ibuf_q;
                default: bus.ifid_instr = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Directed vector table, a hand-written HOLD-into-HALT sequence, and a
// randomized phase checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;
    localparam logic [31:0] HW      = 32'hFC00_0000;

    logic CLK;
    logic RST;
    fetch_stage_if bus();

    fetch_stage #(.PC_INIT(PC_INIT), .HALT_WORD(HW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rst;
        bit          ihit;
        logic [31:0] iload;
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        logic [31:0] e_iaddr;
        bit          e_iren;
        bit          e_en;
        bit          e_flush;
        bit          e_halt;
        bit          ci;       // ifid_instr is defined in this row
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns
    // later, well away from the rising edge that updates the design.
    task automatic drive(input bit rst, input bit ihit, input logic [31:0] iload,
                         input bit stall, input bit redir, input logic [31:0] rpc);
        @(negedge CLK);
        RST             = rst;
        bus.ihit        = ihit;
        bus.iload       = iload;
        bus.stall       = stall;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        #1;
    endtask

    task automatic add(input bit rst, input bit ihit, input logic [31:0] iload,
                       input bit stall, input bit redir, input logic [31:0] rpc,
                       input logic [31:0] e_iaddr, input bit e_iren, input bit e_en,
                       input bit e_flush, input bit e_halt, input bit ci,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic [31:0] e_count);
        vec_t v;
        v.rst = rst; v.ihit = ihit; v.iload = iload; v.stall = stall;
        v.redir = redir; v.rpc = rpc; v.e_iaddr = e_iaddr; v.e_iren = e_iren;
        v.e_en = e_en; v.e_flush = e_flush; v.e_halt = e_halt; v.ci = ci;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_count = e_count;
        vecs.push_back(v);
    endtask

    // Reference model state: the PC, an optional held instruction and
    // whether fetch is parked.
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_held[$];
    bit          m_parked;

    initial begin
        vec_t v;
        logic [31:0] e_pc;

        RST = 1'b1;
        bus.ihit = 1'b0; bus.iload = 32'd0; bus.stall = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
        repeat (2) @(posedge CLK);

        //   rst ihit iload          stall redir rpc           iaddr         iren en fl hl ci instr          pc4           count
        add(1, 0, 32'h0,          0, 0, 32'h0,          32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,        0);
        add(0, 1, 32'h2001_0001,  0, 0, 32'h0,          32'h0,        1, 1, 0, 0, 1, 32'h2001_0001, 32'h4,       0);
        add(0, 1, 32'h2002_0002,  0, 0, 32'h0,          32'h4,        1, 1, 0, 0, 1, 32'h2002_0002, 32'h8,       1);
        add(0, 0, 32'h0,          0, 0, 32'h0,          32'h8,        1, 0, 0, 0, 0, 32'h0,        32'hC,        2);
        add(0, 1, 32'h1111_1111,  0, 0, 32'h0,          32'h8,        1, 1, 0, 0, 1, 32'h1111_1111, 32'hC,       2);
        add(0, 1, 32'h2222_2222,  0, 0, 32'h0,          32'hC,        1, 1, 0, 0, 1, 32'h2222_2222, 32'h10,      3);
        add(0, 1, 32'hAABB_CCDD,  1, 0, 32'h0,          32'h10,       1, 0, 0, 0, 0, 32'h0,        32'h14,       4);
        add(0, 1, 32'h5555_5555,  1, 0, 32'h0,          32'h10,       0, 0, 0, 0, 1, 32'hAABB_CCDD, 32'h14,      4);
        add(0, 1, 32'h5555_5555,  1, 0, 32'h0,          32'h10,       0, 0, 0, 0, 1, 32'hAABB_CCDD, 32'h14,      4);
        add(0, 0, 32'h0,          0, 0, 32'h0,          32'h10,       0, 1, 0, 0, 1, 32'hAABB_CCDD, 32'h14,      4);
        add(0, 1, 32'h3333_3333,  0, 0, 32'h0,          32'h14,       1, 1, 0, 0, 1, 32'h3333_3333, 32'h18,      5);
        add(0, 1, 32'h4444_4444,  0, 0, 32'h0,          32'h18,       1, 1, 0, 0, 1, 32'h4444_4444, 32'h1C,      6);
        add(0, 1, 32'h1234_5678,  0, 0, 32'h0,          32'h1C,       1, 1, 0, 0, 1, 32'h1234_5678, 32'h20,      7);
        add(0, 1, 32'h5555_5555,  0, 1, 32'h100,        32'h20,       1, 0, 1, 0, 0, 32'h0,        32'h24,       8);
        add(0, 0, 32'h0,          0, 1, 32'h40,         32'h100,      1, 0, 1, 0, 0, 32'h0,        32'h104,      8);
        add(0, 1, HW,             0, 0, 32'h0,          32'h40,       1, 1, 0, 0, 1, HW,           32'h44,       8);
        add(0, 1, 32'h0,          0, 0, 32'h0,          32'h44,       0, 0, 0, 1, 0, 32'h0,        32'h48,       9);
        add(0, 0, 32'h0,          0, 1, 32'h80,         32'h44,       0, 0, 1, 1, 0, 32'h0,        32'h48,       9);
        add(0, 0, 32'h0,          0, 0, 32'h0,          32'h80,       1, 0, 0, 0, 0, 32'h0,        32'h84,       9);
        add(0, 1, 32'h6666_6666,  1, 0, 32'h0,          32'h80,       1, 0, 0, 0, 0, 32'h0,        32'h84,       9);
        add(0, 0, 32'h0,          1, 1, 32'h200,        32'h80,       0, 0, 1, 0, 1, 32'h6666_6666, 32'h84,      9);
        add(0, 1, 32'h7777_7777,  0, 0, 32'h0,          32'h200,      1, 1, 0, 0, 1, 32'h7777_7777, 32'h204,     9);
        add(0, 1, 32'h8888_8888,  1, 0, 32'h0,          32'h204,      1, 0, 0, 0, 0, 32'h0,        32'h208,      10);
        add(1, 1, 32'h0,          1, 1, 32'h300,        32'h204,      0, 0, 0, 0, 1, 32'h0,        32'h0,        10);
        add(0, 0, 32'h0,          0, 0, 32'h0,          PC_INIT,      1, 0, 0, 0, 0, 32'h0,        32'h4,        0);
        add(0, 0, 32'h0,          0, 1, 32'hFFFF_FFFC,  32'h0,        1, 0, 1, 0, 0, 32'h0,        32'h4,        0);
        add(0, 1, 32'h9999_9999,  0, 0, 32'h0,          32'hFFFF_FFFC, 1, 1, 0, 0, 1, 32'h9999_9999, 32'h0,      0);
        add(0, 0, 32'h0,          0, 0, 32'h0,          32'h0,        1, 0, 0, 0, 0, 32'h0,        32'h4,        1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rst, v.ihit, v.iload, v.stall, v.redir, v.rpc);
            e_pc = v.rst ? 32'h0 : v.e_iaddr;
            $display("vec %0d: iaddr=%h iREN=%0b en=%0b flush=%0b halted=%0b instr=%h count=%0d",
                     i, bus.iaddr, bus.iREN, bus.ifid_en, bus.ifid_flush, bus.halted,
                     bus.ifid_instr, bus.fetch_count);
            chk($sformatf("v%0d_iaddr", i), bus.iaddr, v.e_iaddr);
            chk($sformatf("v%0d_iREN", i), {31'd0, bus.iREN}, {31'd0, v.e_iren});
            chk($sformatf("v%0d_en", i), {31'd0, bus.ifid_en}, {31'd0, v.e_en});
            chk($sformatf("v%0d_flush", i), {31'd0, bus.ifid_flush}, {31'd0, v.e_flush});
            chk($sformatf("v%0d_halted", i), {31'd0, bus.halted}, {31'd0, v.e_halt});
            chk($sformatf("v%0d_pc", i), bus.ifid_pc, e_pc);
            chk($sformatf("v%0d_pc4", i), bus.ifid_pc4, v.e_pc4);
            chk($sformatf("v%0d_next_pc", i), bus.ifid_next_pc, v.e_pc4);
            chk($sformatf("v%0d_count", i), bus.fetch_count, v.e_count);
            if (v.ci) chk($sformatf("v%0d_instr", i), bus.ifid_instr, v.e_instr);
        end

        // Hand sequence: HALT word caught in the skid buffer during a long
        // stall, released, then fetch stays parked until a redirect.
        // Starts at pc=0, count=1.
        drive(0, 1, HW, 1, 0, 32'h0);
        $display("seq: HALT word captured under stall at iaddr=%h", bus.iaddr);
        chk("seq_cap_iren", {31'd0, bus.iREN}, 32'd1);
        chk("seq_cap_en", {31'd0, bus.ifid_en}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, $urandom, 1, 0, 32'h0);
            $display("seq: hold cycle %0d instr=%h", k, bus.ifid_instr);
            chk("seq_hold_iren", {31'd0, bus.iREN}, 32'd0);
            chk("seq_hold_en", {31'd0, bus.ifid_en}, 32'd0);
            chk("seq_hold_instr", bus.ifid_instr, HW);
        end
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        $display("seq: release en=%0b instr=%h", bus.ifid_en, bus.ifid_instr);
        chk("seq_rel_en", {31'd0, bus.ifid_en}, 32'd1);
        chk("seq_rel_instr", bus.ifid_instr, HW);
        chk("seq_rel_pc", bus.ifid_pc, 32'h0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, $urandom, k[0], 0, 32'h0);
            $display("seq: parked cycle %0d halted=%0b", k, bus.halted);
            chk("seq_park_halted", {31'd0, bus.halted}, 32'd1);
            chk("seq_park_iren", {31'd0, bus.iREN}, 32'd0);
            chk("seq_park_en", {31'd0, bus.ifid_en}, 32'd0);
            chk("seq_park_count", bus.fetch_count, 32'd2);
            chk("seq_park_iaddr", bus.iaddr, 32'h4);
        end
        drive(0, 0, 32'h0, 1, 1, 32'h0);
        chk("seq_unpark_flush", {31'd0, bus.ifid_flush}, 32'd1);
        chk("seq_unpark_en", {31'd0, bus.ifid_en}, 32'd0);

        // Randomized phase against the reference model; begins with reset.
        m_pc = 32'h0; m_count = 32'h0; m_parked = 1'b0; m_held.delete();
        for (int c = 0; c < 800; c++) begin
            bit          r_rst, r_ihit, r_stall, r_redir, fetching, have, take;
            logic [31:0] r_load, r_rpc, instr;
            r_rst   = (c == 0) || ($urandom_range(0, 39) == 0);
            r_ihit  = ($urandom_range(0, 3) != 0);
            r_stall = ($urandom_range(0, 2) == 0);
            r_redir = ($urandom_range(0, 9) == 0);
            r_load  = ($urandom_range(0, 7) == 0) ? HW : $urandom;
            r_rpc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            drive(r_rst, r_ihit, r_load, r_stall, r_redir, r_rpc);

            if (c == 0) begin
                chk("rnd_reset_iren", {31'd0, bus.iREN}, 32'd0);
            end else if (r_rst) begin
                chk("rnd_rst_iren", {31'd0, bus.iREN}, 32'd0);
                chk("rnd_rst_en", {31'd0, bus.ifid_en}, 32'd0);
                chk("rnd_rst_flush", {31'd0, bus.ifid_flush}, 32'd0);
                chk("rnd_rst_halted", {31'd0, bus.halted}, 32'd0);
                chk("rnd_rst_pc", bus.ifid_pc, 32'h0);
                chk("rnd_rst_instr", bus.ifid_instr, 32'h0);
            end else begin
                fetching = !m_parked && (m_held.size() == 0);
                have     = (m_held.size() != 0) || (fetching && r_ihit);
                take     = have && !r_redir && !r_stall;
                instr    = (m_held.size() != 0) ? m_held[0] : r_load;
                chk("rnd_iaddr", bus.iaddr, m_pc);
                chk("rnd_iren", {31'd0, bus.iREN}, {31'd0, fetching});
                chk("rnd_en", {31'd0, bus.ifid_en}, {31'd0, take});
                chk("rnd_flush", {31'd0, bus.ifid_flush}, {31'd0, r_redir});
                chk("rnd_halted", {31'd0, bus.halted}, {31'd0, m_parked});
                chk("rnd_pc", bus.ifid_pc, m_pc);
                chk("rnd_pc4", bus.ifid_pc4, m_pc + 32'd4);
                chk("rnd_next_pc", bus.ifid_next_pc, m_pc + 32'd4);
                chk("rnd_count", bus.fetch_count, m_count);
                if (take || m_held.size() != 0) chk("rnd_instr", bus.ifid_instr, instr);
                if (take)
                    $display("rnd %0d: accept pc=%h instr=%h count=%0d",
                             c, m_pc, instr, m_count + 1);
            end

            // Advance the model by one clock.
            if (r_rst) begin
                m_pc = PC_INIT; m_count = 32'h0; m_parked = 1'b0; m_held.delete();
            end else if (r_redir) begin
                m_pc = r_rpc; m_parked = 1'b0; m_held.delete();
            end else if (m_held.size() != 0) begin
                if (!r_stall) begin
                    instr    = m_held.pop_front();
                    m_pc     = m_pc + 32'd4;
                    m_count  = m_count + 32'd1;
                    m_parked = (instr == HW);
                end
            end else if (!m_parked && r_ihit) begin
                if (r_stall) begin
                    m_held.push_back(r_load);
                end else begin
                    m_pc     = m_pc + 32'd4;
                    m_count  = m_count + 32'd1;
                    m_parked = (r_load == HW);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
